// File: rtl/weight_row_mapping_table.sv
// Logical-weight-row -> physical-PE-row map builder fed by the faulty-PE storage match results.
// Latency: a result applies one cycle after its weight_valid; all outputs are registered (one more cycle).
// Backpressure: none; one result per cycle accepted in ALLOC, ignored in IDLE/DONE/FAIL until init_en.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   init_en                clear map, latch faulty_rows_mask, start allocation
//   faulty_rows_mask       bit r set: physical row r contains faulty PEs
//   weight_valid           weight strobe (also seen by storage), current_row_addr = its logical row
//   match_success/failed   storage answer one cycle after weight_valid, faulty_row_addr = chosen row
//   map_phys_flat          entry L at [L*ADDR_WIDTH +: ADDR_WIDTH]
//   map_valid, phys_used   per-logical-row written / per-physical-row allocated
//   alloc_done, alloc_error, err_row_addr, proto_err, busy   status
module weight_row_mapping_table #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                init_en,
    input  logic [SYSTOLIC_SIZE-1:0]            faulty_rows_mask,
    input  logic                                weight_valid,
    input  logic [ADDR_WIDTH-1:0]               current_row_addr,
    input  logic                                match_success,
    input  logic                                match_failed,
    input  logic [ADDR_WIDTH-1:0]               faulty_row_addr,
    output logic [SYSTOLIC_SIZE*ADDR_WIDTH-1:0] map_phys_flat,
    output logic [SYSTOLIC_SIZE-1:0]            map_valid,
    output logic [SYSTOLIC_SIZE-1:0]            phys_used,
    output logic                                alloc_done,
    output logic                                alloc_error,
    output logic [ADDR_WIDTH-1:0]               err_row_addr,
    output logic                                proto_err,
    output logic                                busy
);

    typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_DONE, S_FAIL} state_t;

    state_t                                     state_q, state_d;
    logic [SYSTOLIC_SIZE-1:0][ADDR_WIDTH-1:0]   map_q, map_d;
    logic [SYSTOLIC_SIZE-1:0]                   map_valid_q, map_valid_d;
    logic [SYSTOLIC_SIZE-1:0]                   phys_used_q, phys_used_d;
    logic [SYSTOLIC_SIZE-1:0]                   mask_q, mask_d;
    logic                                       pend_vld_q, pend_vld_d;
    logic [ADDR_WIDTH-1:0]                      pend_row_q, pend_row_d;
    logic                                       alloc_done_q, alloc_done_d;
    logic                                       alloc_error_q, alloc_error_d;
    logic [ADDR_WIDTH-1:0]                      err_row_q, err_row_d;
    logic                                       proto_err_q, proto_err_d;
    logic                                       busy_q, busy_d;

    // Lowest-indexed fault-free row not yet allocated, from registered state only.
    logic [SYSTOLIC_SIZE-1:0] free_vec;
    logic                     free_any;
    logic [ADDR_WIDTH-1:0]    free_idx;

    assign free_vec = ~mask_q & ~phys_used_q;
    assign free_any = |free_vec;

    always_comb begin
        free_idx = '0;
        for (int i = SYSTOLIC_SIZE - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = ADDR_WIDTH'(i);
        end
    end

    // Result classification. A malformed result (neither/both strobes) or one for an
    // already-mapped logical row is discarded; a success onto an already-used physical
    // row is flagged but still written.
    logic                     res_take, res_proto, res_write, res_nofree, res_dup;
    logic [ADDR_WIDTH-1:0]    res_phys;
    logic [SYSTOLIC_SIZE-1:0] row_onehot, map_valid_nxt;

    assign res_take      = pend_vld_q && (state_q == S_ALLOC) && !init_en;
    assign res_proto     = (match_success == match_failed) || map_valid_q[pend_row_q];
    assign res_write     = res_take && !res_proto && (match_success || free_any);
    assign res_nofree    = res_take && !res_proto && match_failed && !free_any;
    assign res_dup       = res_take && !res_proto && match_success && phys_used_q[faulty_row_addr];
    assign res_phys      = match_success ? faulty_row_addr : free_idx;
    assign row_onehot    = SYSTOLIC_SIZE'(1) << pend_row_q;
    assign map_valid_nxt = map_valid_q | (res_write ? row_onehot : '0);

    // State register (all flops).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            map_q         <= '0;
            map_valid_q   <= '0;
            phys_used_q   <= '0;
            mask_q        <= '0;
            pend_vld_q    <= 1'b0;
            pend_row_q    <= '0;
            alloc_done_q  <= 1'b0;
            alloc_error_q <= 1'b0;
            err_row_q     <= '0;
            proto_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            map_q         <= map_d;
            map_valid_q   <= map_valid_d;
            phys_used_q   <= phys_used_d;
            mask_q        <= mask_d;
            pend_vld_q    <= pend_vld_d;
            pend_row_q    <= pend_row_d;
            alloc_done_q  <= alloc_done_d;
            alloc_error_q <= alloc_error_d;
            err_row_q     <= err_row_d;
            proto_err_q   <= proto_err_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (init_en) begin
            state_d = S_ALLOC;
        end else if (state_q == S_ALLOC) begin
            if (res_nofree)            state_d = S_FAIL;
            else if (&map_valid_nxt)   state_d = S_DONE;
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        map_d         = map_q;
        map_valid_d   = map_valid_q;
        phys_used_d   = phys_used_q;
        mask_d        = mask_q;
        pend_vld_d    = (state_q == S_ALLOC) && weight_valid;
        pend_row_d    = weight_valid ? current_row_addr : pend_row_q;
        alloc_error_d = alloc_error_q;
        err_row_d     = err_row_q;
        proto_err_d   = proto_err_q;
        busy_d        = (state_d == S_ALLOC);
        alloc_done_d  = (state_d == S_DONE);
        if (init_en) begin
            map_d         = '0;
            map_valid_d   = '0;
            phys_used_d   = '0;
            mask_d        = faulty_rows_mask;
            pend_vld_d    = 1'b0;
            alloc_error_d = 1'b0;
            err_row_d     = '0;
            proto_err_d   = 1'b0;
        end else begin
            if (res_write) begin
                map_d[pend_row_q]     = res_phys;
                map_valid_d           = map_valid_nxt;
                phys_used_d[res_phys] = 1'b1;
            end
            if (res_nofree) begin
                alloc_error_d = 1'b1;
                err_row_d     = pend_row_q;
            end
            if (res_take && (res_proto || res_dup)) proto_err_d = 1'b1;
        end
    end

    assign map_phys_flat = map_q;
    assign map_valid     = map_valid_q;
    assign phys_used     = phys_used_q;
    assign alloc_done    = alloc_done_q;
    assign alloc_error   = alloc_error_q;
    assign err_row_addr  = err_row_q;
    assign proto_err     = proto_err_q;
    assign busy          = busy_q;

endmodule

// File: doc/weight_row_mapping_table.md
Name: weight_row_mapping_table

Overview:
- Downstream consumer of the faulty-PE storage's match results.
- Builds the logical-weight-row → physical-PE-row map for the systolic array.
- Match success (steps 2/3): maps the logical row onto the reported faulty physical row.
- Match failure (step 4): allocates the lowest-indexed unused fault-free physical row.
- Exports the finished map, completion status and error status to the array controller and recovery-check logic.

Parameters:
SYSTOLIC_SIZE, 8, number of logical weight rows and of physical PE rows
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
init_en  input  1  clear map, latch faulty_rows_mask, enter ALLOC
faulty_rows_mask  input  SYSTOLIC_SIZE  bit r=1: physical row r has faulty PEs
weight_valid  input  1  same strobe driven to the storage block
current_row_addr  input  ADDR_WIDTH  logical row of the weight presented with weight_valid
match_success  input  1  storage result: map to faulty_row_addr
match_failed  input  1  storage result: perform step 4
faulty_row_addr  input  ADDR_WIDTH  faulty physical row chosen by storage
map_phys_flat  output  SYSTOLIC_SIZE*ADDR_WIDTH  entry L at [L*ADDR_WIDTH +: ADDR_WIDTH] = physical row for logical row L
map_valid  output  SYSTOLIC_SIZE  bit L=1: entry L written
phys_used  output  SYSTOLIC_SIZE  bit r=1: physical row r allocated
alloc_done  output  1  all logical rows mapped (level)
alloc_error  output  1  step 4 found no free fault-free row (level, sticky until init/reset)
err_row_addr  output  ADDR_WIDTH  logical row that caused alloc_error
proto_err  output  1  sticky protocol-violation flag
busy  output  1  high in ALLOC

Behaviour:
- Reset: all outputs 0, map entries 0, latched mask 0, pending 0, state IDLE.
- States: IDLE, ALLOC, DONE, FAIL. All outputs are registered.
- init_en (any state): next cycle map_valid=0, phys_used=0, flags cleared, mask latched, pending cleared, state=ALLOC.
  - Any result arriving in the same cycle as init_en is dropped. init_en has priority.
- Pending capture: in ALLOC, weight_valid captures pending_valid=1 and pending_row=current_row_addr. The storage answers exactly one cycle later.
  - Back-to-back weight_valid is allowed: one result per cycle, pipelined.
  - Outside ALLOC, weight_valid is ignored.
- Result cycle (pending_valid=1):
  - match_success only:
    - entry[pending_row]=faulty_row_addr, map_valid[pending_row]=1, phys_used[faulty_row_addr]=1.
  - match_failed only:
    - free = ~mask & ~phys_used. Pick the lowest set index f.
    - If free≠0: entry[pending_row]=f, map_valid and phys_used[f] set.
    - If free=0: alloc_error=1, err_row_addr=pending_row, state=FAIL.
  - Neither, or both: proto_err=1. Map unchanged; the pending result is discarded.
  - pending_row already has map_valid=1: proto_err=1, existing entry kept, no allocation.
  - phys_used[faulty_row_addr] already set on success: proto_err=1, entry still written.
- Result arriving with pending_valid=0 is ignored.
- Completion: when the write makes map_valid all-ones, state=DONE and alloc_done=1 in the same registered update. busy=0 from then on.
  - In DONE and FAIL, weight_valid and results are ignored until init_en.
- Allocation is combinational from registered phys_used. Same-cycle capture of a new weight_valid alongside a result is allowed.
- Async reset mid-operation clears everything immediately. No result is applied after reset deasserts without a new init_en.

Test Plan:
- Init with mask=8'b0000_0100. Weight rows 0..7 → success for row 0 (faulty_row_addr=2), then failed for rows 1..7 → entry0=2, entries1..7=0,1,3,4,5,6,7; alloc_done=1 and busy=0 in the cycle after the last result.
- Mask=8'hFF, one weight row 3 with match_failed → next cycle alloc_error=1, err_row_addr=3, state FAIL; a later weight_valid changes nothing.
- Back-to-back weight_valid rows 5,6 with results failed,failed and mask=0 → entry5=0, entry6=1, phys_used=8'b0000_0011.
- Weight_valid row 2, next cycle both match_success and match_failed high → proto_err=1, map_valid[2]=0; the same with neither high also sets proto_err.
- init_en asserted coincident with a match_success result → result dropped, map_valid=0, busy=1 next cycle.
- Assert rst_n=0 mid-ALLOC after 3 rows mapped → all outputs 0 immediately; after release, match results are ignored until init_en.
